// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_kbd_pkg;

    // Deframer states, one per field of the 11-bit frame after the start bit.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    // Bit positions inside the CPU-visible status byte.
    localparam int STAT_READY = 0;
    localparam int STAT_PERR  = 6;
    localparam int STAT_OVF   = 7;

    // True when data plus parity bit carry an odd number of ones.
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_kbd_if.sv
// CPU-side register interface of the keyboard receiver.
interface ps2_kbd_if;
    logic       rd;
    logic       clr;
    logic [7:0] q;
    logic [7:0] status;
    logic       intr;
    logic [2:0] vect;

    modport master (output rd, output clr, input q, input status, input intr, input vect);
    modport slave  (input rd, input clr, output q, output status, output intr, output vect);
endinterface

// File: rtl/ps2_kbd_sync_fifo.sv
// Small synchronous FIFO: registered storage, combinational head read.
module ps2_kbd_sync_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      head,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  do_push;
    logic                  do_pop;

    // A pop frees the head slot in the same cycle, so a full FIFO still accepts a push.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && (!full || do_pop);
    assign full    = count_q[DEPTH_LOG2];
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];

    // Storage write; no reset needed since the head is only used while count is non-zero.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ps2_kbd.sv
// PS/2 keyboard receiver: pin synchronizers, frame deframer with idle timeout,
// byte FIFO and sticky error flags, exposed as data/status registers plus irq.
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_IDLE   | waiting for a start bit (falling clock with data low)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | waiting for the parity bit
// ST_STOP   | waiting for the stop bit; push or flag error on its fall
module ps2_kbd
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned TIMEOUT    = 50000,
    parameter logic [2:0]  VECTOR     = 3'd1
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      ps2_clk,
    input  logic      ps2_dat,
    ps2_kbd_if.slave  bus
);
    localparam int unsigned   TW         = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT - 1);

    logic clk_s1, clk_s2, clk_prev;
    logic dat_s1, dat_s2;
    logic fall_w;

    ps2_state_e state_q, state_d;
    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic       par_q;
    logic [TW-1:0] timer_q;
    logic       timeout_w;

    logic       push_w;
    logic       perr_set_w;
    logic       ovf_set_w;
    logic       perr_q;
    logic       ovf_q;

    logic [7:0]          fifo_head;
    logic                fifo_full;
    logic [DEPTH_LOG2:0] fifo_count;
    logic                ready;

    // Two-flop synchronizers on both pins plus one history flop on the clock pin.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_dat;
            dat_s2   <= dat_s1;
        end
    end

    assign fall_w    = clk_prev & ~clk_s2;
    // A fall in the terminal cycle counts as activity, so it wins over the abort.
    assign timeout_w = (state_q != ST_IDLE) && (timer_q == '0) && !fall_w;

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic; every field advances only on a PS/2 clock fall.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (fall_w && !dat_s2)           state_d = ST_DATA;
            ST_DATA:   if (fall_w && bit_cnt_q == 3'd7) state_d = ST_PARITY;
            ST_PARITY: if (fall_w)                      state_d = ST_STOP;
            ST_STOP:   if (fall_w)                      state_d = ST_IDLE;
            default:                                    state_d = ST_IDLE;
        endcase
        if (timeout_w) state_d = ST_IDLE;
    end

    // FSM outputs: byte push or parity/framing error on the stop-bit fall.
    always_comb begin
        push_w     = 1'b0;
        perr_set_w = 1'b0;
        if (state_q == ST_STOP && fall_w) begin
            if (dat_s2 && parity_ok(shift_q, par_q)) push_w     = 1'b1;
            else                                     perr_set_w = 1'b1;
        end
    end

    // Frame datapath: bit counter, LSB-first shift register, parity latch.
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
        end else begin
            if (state_q == ST_IDLE) bit_cnt_q <= '0;
            if (state_q == ST_DATA && fall_w) begin
                shift_q   <= {dat_s2, shift_q[7:1]};
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
            if (state_q == ST_PARITY && fall_w) par_q <= dat_s2;
        end
    end

    // Mid-frame inactivity timer, down-counting from TIMEOUT-1 since the last fall.
    always_ff @(posedge clock) begin
        if (reset || state_q == ST_IDLE || fall_w) timer_q <= TIMER_LOAD;
        else if (timer_q != '0)                    timer_q <= timer_q - 1'b1;
    end

    assign ready     = (fifo_count != '0);
    assign ovf_set_w = push_w && fifo_full && !(bus.rd && ready);

    // Sticky error flags; a new error in the clear cycle keeps the flag set.
    always_ff @(posedge clock) begin
        if (reset) begin
            perr_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (perr_set_w)   perr_q <= 1'b1;
            else if (bus.clr) perr_q <= 1'b0;
            if (ovf_set_w)    ovf_q  <= 1'b1;
            else if (bus.clr) ovf_q  <= 1'b0;
        end
    end

    ps2_kbd_sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_w),
        .pop   (bus.rd),
        .wdata (shift_q),
        .head  (fifo_head),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // CPU-visible registers and interrupt pair.
    always_comb begin
        bus.status            = '0;
        bus.status[STAT_OVF]  = ovf_q;
        bus.status[STAT_PERR] = perr_q;
        bus.status[STAT_READY] = ready;
    end

    assign bus.q    = ready ? fifo_head : 8'h00;
    assign bus.intr = ready;
    assign bus.vect = ready ? VECTOR : 3'd0;

endmodule
